// File: rtl/playback_ctrl.sv
// Playback control: key decode, restart FSM and sample-rate trigger divider.
// Define PLAYBACK_CTRL_RESTART_PLAY_EN to make a restart also start playback.
module playback_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1227,
  parameter int DIV_MIN     = 64,
  parameter int DIV_MAX     = 16000,
  parameter int DIV_STEP    = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  input  logic             speed_up,
  input  logic             speed_down,
  input  logic             speed_reset,
  output logic             trigger,
  output logic             play_enabled,
  output logic             direction,
  output logic             reset_address,
  output logic             reset_to_end,
  output logic [DIV_W-1:0] divider
);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_PLAYING,
    ST_RESTART
  } state_t;

  localparam logic [DIV_W-1:0] L_DEF  = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] L_ONE  = DIV_W'(1);
  localparam logic [DIV_W:0]   L_MIN  = (DIV_W+1)'(DIV_MIN);
  localparam logic [DIV_W:0]   L_MAX  = (DIV_W+1)'(DIV_MAX);
  localparam logic [DIV_W:0]   L_STEP = (DIV_W+1)'(DIV_STEP);

  state_t           r_state;
  state_t           w_next;
  logic             r_dir;
  logic             r_trig;
  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic [2:0]       r_up_s;
  logic [2:0]       r_dn_s;
  logic [2:0]       r_rs_s;
  logic             w_up;
  logic             w_dn;
  logic             w_rs;
  logic [7:0]       w_key;
  logic             w_k_e;
  logic             w_k_d;
  logic             w_k_f;
  logic             w_k_b;
  logic             w_k_r;
  logic             w_run;
  logic [DIV_W:0]   w_dec;
  logic [DIV_W:0]   w_inc;

  // Clearing bit 5 folds lowercase ASCII onto uppercase.
  assign w_key = key_code & 8'hDF;
  assign w_k_e = key_valid && (w_key == 8'h45);
  assign w_k_d = key_valid && (w_key == 8'h44);
  assign w_k_f = key_valid && (w_key == 8'h46);
  assign w_k_b = key_valid && (w_key == 8'h42);
  assign w_k_r = key_valid && (w_key == 8'h52);

`ifndef PLAYBACK_CTRL_RESTART_PLAY_EN
  state_t r_prior;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prior <= ST_STOPPED;
    end else if (w_next == ST_RESTART &&
                 r_state != ST_RESTART) begin
      r_prior <= r_state;
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_STOPPED, ST_PLAYING: begin
        if (w_k_r)      w_next = ST_RESTART;
        else if (w_k_e) w_next = ST_PLAYING;
        else if (w_k_d) w_next = ST_STOPPED;
      end
      ST_RESTART: begin
`ifdef PLAYBACK_CTRL_RESTART_PLAY_EN
        w_next = ST_PLAYING;
`else
        w_next = r_prior;
`endif
        if (w_k_e)      w_next = ST_PLAYING;
        else if (w_k_d) w_next = ST_STOPPED;
      end
      default: w_next = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_STOPPED;
      r_dir   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_k_f)      r_dir <= 1'b1;
      else if (w_k_b) r_dir <= 1'b0;
    end
  end

  // Counter only runs while staying in PLAYING; anything else reloads.
  assign w_run = (r_state == ST_PLAYING) &&
                 (w_next == ST_PLAYING);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trig  <= 1'b0;
      r_count <= L_DEF - L_ONE;
    end else if (w_run) begin
      if (r_count == '0) begin
        r_trig  <= 1'b1;
        r_count <= r_div - L_ONE;
      end else begin
        r_trig  <= 1'b0;
        r_count <= r_count - L_ONE;
      end
    end else begin
      r_trig  <= 1'b0;
      r_count <= r_div - L_ONE;
    end
  end

  // Bits [1:0] synchronize; bit 2 is the previous value for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_up_s <= '0;
      r_dn_s <= '0;
      r_rs_s <= '0;
    end else begin
      r_up_s <= {r_up_s[1:0], speed_up};
      r_dn_s <= {r_dn_s[1:0], speed_down};
      r_rs_s <= {r_rs_s[1:0], speed_reset};
    end
  end

  assign w_up = r_up_s[1] & ~r_up_s[2];
  assign w_dn = r_dn_s[1] & ~r_dn_s[2];
  assign w_rs = r_rs_s[1] & ~r_rs_s[2];

  assign w_dec = {1'b0, r_div} - L_STEP;
  assign w_inc = {1'b0, r_div} + L_STEP;

  always_comb begin
    w_div_next = r_div;
    if (w_rs) begin
      w_div_next = L_DEF;
    end else if (w_up && !w_dn) begin
      if (w_dec[DIV_W] || w_dec < L_MIN)
        w_div_next = L_MIN[DIV_W-1:0];
      else
        w_div_next = w_dec[DIV_W-1:0];
    end else if (w_dn && !w_up) begin
      if (w_inc > L_MAX)
        w_div_next = L_MAX[DIV_W-1:0];
      else
        w_div_next = w_inc[DIV_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_div <= L_DEF;
    else          r_div <= w_div_next;
  end

  assign trigger       = r_trig;
  assign play_enabled  = (r_state == ST_PLAYING);
  assign direction     = r_dir;
  assign reset_address = (r_state == ST_RESTART);
  assign reset_to_end  = (r_state == ST_RESTART) & ~r_dir;
  assign divider       = r_div;

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl: keys, restart, trigger timing,
// speed buttons and asynchronous reset.
module tb_playback_ctrl;

  localparam int D = 1227;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        speed_up;
  logic        speed_down;
  logic        speed_reset;
  logic        trigger;
  logic        play_enabled;
  logic        direction;
  logic        reset_address;
  logic        reset_to_end;
  logic [15:0] divider;

  int n_pass  = 0;
  int n_total = 0;

  playback_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .speed_up     (speed_up),
    .speed_down   (speed_down),
    .speed_reset  (speed_reset),
    .trigger      (trigger),
    .play_enabled (play_enabled),
    .direction    (direction),
    .reset_address(reset_address),
    .reset_to_end (reset_to_end),
    .divider      (divider)
  );

  always #5 clk = ~clk;

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic wait_trig(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (trigger === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic press(input logic up, input logic dn,
                       input logic rs);
    @(negedge clk);
    speed_up    = up;
    speed_down  = dn;
    speed_reset = rs;
    repeat (4) @(posedge clk);
    @(negedge clk);
    speed_up    = 1'b0;
    speed_down  = 1'b0;
    speed_reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_total++;
    if ({trigger, play_enabled, direction,
         reset_address, reset_to_end} !== 5'b00100)
      $display("FAIL reset_flags got %b want 00100",
        {trigger, play_enabled, direction,
         reset_address, reset_to_end});
    else n_pass++;
    n_total++;
    if (divider !== 16'd1227)
      $display("FAIL reset_div got %0d want 1227", divider);
    else n_pass++;
  endtask

  task automatic test_play;
    int n;
    send_key(8'h45);
    n_total++;
    if (play_enabled !== 1'b1)
      $display("FAIL play_en got %b want 1", play_enabled);
    else n_pass++;
    wait_trig(3000, n);
    n_total++;
    if (n !== D)
      $display("FAIL first_trig got %0d want %0d", n, D);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (trigger !== 1'b0)
      $display("FAIL trig_width got %b want 0", trigger);
    else n_pass++;
    wait_trig(3000, n);
    n_total++;
    if (n !== D - 1)
      $display("FAIL second_trig got %0d want %0d", n, D - 1);
    else n_pass++;
  endtask

  task automatic test_restart;
    int n;
    // Land the restart on the edge where a trigger would fire.
    repeat (D - 1) @(posedge clk);
    send_key(8'h52);
    n_total++;
    if ({reset_address, reset_to_end, trigger} !== 3'b100)
      $display("FAIL restart_pulse got %b want 100",
        {reset_address, reset_to_end, trigger});
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({reset_address, play_enabled} !== 2'b01)
      $display("FAIL restart_exit got %b want 01",
        {reset_address, play_enabled});
    else n_pass++;
    wait_trig(3000, n);
    n_total++;
    if (n !== D)
      $display("FAIL restart_trig got %0d want %0d", n, D);
    else n_pass++;
  endtask

  task automatic test_stop_mid;
    int n;
    int cnt;
    repeat (500) @(posedge clk);
    send_key(8'h44);
    n_total++;
    if ({play_enabled, trigger} !== 2'b00)
      $display("FAIL stop got %b want 00",
        {play_enabled, trigger});
    else n_pass++;
    cnt = 0;
    for (int i = 0; i < 1300; i++) begin
      @(posedge clk);
      #1;
      if (trigger === 1'b1) cnt++;
    end
    n_total++;
    if (cnt !== 0)
      $display("FAIL stopped_trig got %0d want 0", cnt);
    else n_pass++;
    send_key(8'h65);
    wait_trig(3000, n);
    n_total++;
    if (n !== D)
      $display("FAIL replay_trig got %0d want %0d", n, D);
    else n_pass++;
    send_key(8'h64);
    n_total++;
    if (play_enabled !== 1'b0)
      $display("FAIL stop2 got %b want 0", play_enabled);
    else n_pass++;
  endtask

  task automatic test_back_restart;
    logic exp_play;
`ifdef PLAYBACK_CTRL_RESTART_PLAY_EN
    exp_play = 1'b1;
`else
    exp_play = 1'b0;
`endif
    send_key(8'h62);
    n_total++;
    if (direction !== 1'b0)
      $display("FAIL dir_b got %b want 0", direction);
    else n_pass++;
    send_key(8'h72);
    n_total++;
    if ({reset_address, reset_to_end} !== 2'b11)
      $display("FAIL back_pulse got %b want 11",
        {reset_address, reset_to_end});
    else n_pass++;
    // Second R lands in RESTART and must be ignored.
    send_key(8'h52);
    n_total++;
    if ({reset_address, play_enabled} !== {1'b0, exp_play})
      $display("FAIL back_exit got %b want %b",
        {reset_address, play_enabled}, {1'b0, exp_play});
    else n_pass++;
    send_key(8'h66);
    n_total++;
    if (direction !== 1'b1)
      $display("FAIL dir_f got %b want 1", direction);
    else n_pass++;
    send_key(8'h58);
    n_total++;
    if ({direction, play_enabled, reset_address} !==
        {1'b1, exp_play, 1'b0})
      $display("FAIL ignored_key got %b want %b",
        {direction, play_enabled, reset_address},
        {1'b1, exp_play, 1'b0});
    else n_pass++;
    send_key(8'h44);
  endtask

  task automatic test_speed;
    @(negedge clk);
    speed_up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (divider !== 16'd1227)
      $display("FAIL up_early got %0d want 1227", divider);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (divider !== 16'd1163)
      $display("FAIL up_3rd got %0d want 1163", divider);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (divider !== 16'd1163)
      $display("FAIL up_held got %0d want 1163", divider);
    else n_pass++;
    @(negedge clk);
    speed_up = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 17; i++) press(1'b1, 1'b0, 1'b0);
    n_total++;
    if (divider !== 16'd75)
      $display("FAIL up18 got %0d want 75", divider);
    else n_pass++;
    press(1'b1, 1'b0, 1'b0);
    n_total++;
    if (divider !== 16'd64)
      $display("FAIL up19 got %0d want 64", divider);
    else n_pass++;
    press(1'b1, 1'b0, 1'b0);
    n_total++;
    if (divider !== 16'd64)
      $display("FAIL up_floor got %0d want 64", divider);
    else n_pass++;
    for (int i = 0; i < 250; i++) press(1'b0, 1'b1, 1'b0);
    n_total++;
    if (divider !== 16'd16000)
      $display("FAIL dn_ceil got %0d want 16000", divider);
    else n_pass++;
    press(1'b1, 1'b0, 1'b1);
    n_total++;
    if (divider !== 16'd1227)
      $display("FAIL up_rst got %0d want 1227", divider);
    else n_pass++;
    press(1'b1, 1'b1, 1'b0);
    n_total++;
    if (divider !== 16'd1227)
      $display("FAIL up_dn got %0d want 1227", divider);
    else n_pass++;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    n_total++;
    if (divider !== 16'd1163)
      $display("FAIL up_dn2 got %0d want 1163", divider);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    int cnt;
    send_key(8'h42);
    send_key(8'h45);
    repeat (100) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({trigger, play_enabled, direction,
         reset_address, reset_to_end} !== 5'b00100)
      $display("FAIL arst_flags got %b want 00100",
        {trigger, play_enabled, direction,
         reset_address, reset_to_end});
    else n_pass++;
    n_total++;
    if (divider !== 16'd1227)
      $display("FAIL arst_div got %0d want 1227", divider);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (reset_address || play_enabled || trigger) cnt++;
    end
    n_total++;
    if (cnt !== 0)
      $display("FAIL arst_quiet got %0d want 0", cnt);
    else n_pass++;
    send_key(8'h45);
    send_key(8'h52);
    n_total++;
    if (reset_address !== 1'b1)
      $display("FAIL mid_rst_pulse got %b want 1",
        reset_address);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({reset_address, play_enabled} !== 2'b00)
      $display("FAIL mid_rst got %b want 00",
        {reset_address, play_enabled});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (reset_address || play_enabled) cnt++;
    end
    n_total++;
    if (cnt !== 0)
      $display("FAIL mid_rst_quiet got %0d want 0", cnt);
    else n_pass++;
  endtask

  initial begin
    reset_n     = 1'b0;
    key_valid   = 1'b0;
    key_code    = 8'h00;
    speed_up    = 1'b0;
    speed_down  = 1'b0;
    speed_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_play;
    test_restart;
    test_stop_mid;
    test_back_restart;
    test_speed;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
